// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage CPU. It drives the write
// enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the
// PC enable. It detects load-use and taken-branch hazards, sequences
// multi-cycle mul/div stalls, and picks the EX-stage operand forwarding paths.
//
// Parameters
//   REG_W   register-number width
//   MD_LAT  total stall cycles for one mul/div op (>= 2)
//
// Ports
//   clk, Rst                     clock, synchronous active-high reset
//   id_rs/id_rt, id_use_rs/rt    sources of the ID instruction and use flags
//   ex_rs/ex_rt/ex_rd            sources and destination of the EX instruction
//   ex_regwrite, ex_memread      EX writes a register / EX is a load
//   ex_branch_taken              EX resolved a taken branch or jump
//   ex_md_start                  EX holds a mul/div op
//   mem_rd/wb_rd, *_regwrite     destinations and write enables in MEM and WB
//   pc_we, *_we                  pipeline register write enables
//   ifid/idex/exmem_flush        bubble insertion into the next stage
//   fwd_a, fwd_b                 00 regfile, 10 EX/MEM result, 01 MEM/WB result
//   md_busy, md_done             mul/div stall active / final release cycle
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 4
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy,
  output logic             md_done
);

  // Counter width; a one-bit counter is kept when MD_LAT is 2 so the
  // vector never collapses to zero width.
  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            load_use;
  logic            md_stall;

  // ex_regwrite is part of the stage interface but every hazard decided here
  // keys off ex_memread alone (a load always writes a register).
  logic            unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  // Forwarding source for one EX operand. MEM holds the younger result so it
  // wins over WB; register 0 is hardwired and never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))
      sel = 2'b10;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
      sel = 2'b01;
    return sel;
  endfunction

  // State and stall counter register; reset aborts any stall in progress.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Mul/div sequencer. The IDLE entry cycle is already a stall cycle, so BUSY
  // only has to cover MD_LAT-1 more cycles: cnt starts at MD_LAT-2 and BUSY
  // exits when it reaches zero. DONE ignores ex_md_start because the op that
  // caused the stall is the one leaving EX in that cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (ex_md_start) begin
          state_nxt = BUSY;
          cnt_nxt   = CW'(MD_LAT - 2);
        end
      end
      BUSY: begin
        if (cnt != '0)
          cnt_nxt = cnt - CW'(1);
        else
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

  assign md_stall = ((state == IDLE) && ex_md_start) || (state == BUSY);

  // Enable/flush generation. Reset forces all stages to flush so no stale
  // instruction survives; otherwise mul/div beats branch beats load-use.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    if (Rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      fwd_a   = fwd_sel(ex_rs);
      fwd_b   = fwd_sel(ex_rt);
      md_busy = md_stall;
      md_done = (state == DONE);
      if (md_stall) begin
        // Freeze front end and the op in EX; drain older work to WB.
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_flush = 1'b1;
      end else if (ex_branch_taken) begin
        // Squash the two wrong-path instructions in IF and ID.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        // Hold IF/ID one cycle and send a bubble into EX.
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

endmodule
